// File: rtl/rib_arbiter.sv
// rib_arbiter
// Shares the single RIB slave bus between three masters:
//   m0 = core load/store, m1 = core instruction fetch, m2 = JTAG debug.
// One winner is registered per transaction; its request is presented to the
// slave until s_ack_i arrives or TIMEOUT GRANT cycles elapse, in which case
// the owner is completed with bus_err_o.
//
// Handshake: a master raises m_req_i[i] with stable we/addr/wdata and holds
// it until the single-cycle m_ack_o[i] pulse; the arbiter holds s_req_o high
// with stable we/addr/wdata until the single-cycle s_ack_i (or timeout).
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   m_req_i/m_we_i    per-master request / write enable
//   m_addr_i          packed addresses, master i at [i*AW +: AW]
//   m_wdata_i         packed write data, master i at [i*DW +: DW]
//   m_rdata_o         read data, valid with m_ack_o (0 otherwise)
//   m_ack_o           one-hot completion pulse to the owner
//   bus_err_o         pulses with m_ack_o on timeout termination
//   grant_o           one-hot current owner, 0 when idle
//   s_req_o/s_we_o/s_addr_o/s_wdata_o/s_rdata_i/s_ack_i  slave side
//   hold_flag_o       core pipeline stall while a core port is pending
//   dbg_state_o       current FSM state (0 = IDLE, 1 = GRANT)
module rib_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 8,
  parameter int TIMEOUT  = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      m_req_i,
  input  logic [2:0]      m_we_i,
  input  logic [3*AW-1:0] m_addr_i,
  input  logic [3*DW-1:0] m_wdata_i,
  output logic [DW-1:0]   m_rdata_o,
  output logic [2:0]      m_ack_o,
  output logic            bus_err_o,
  output logic [2:0]      grant_o,
  output logic            s_req_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_addr_o,
  output logic [DW-1:0]   s_wdata_o,
  input  logic [DW-1:0]   s_rdata_i,
  input  logic            s_ack_i,
  output logic            hold_flag_o,
  output logic            dbg_state_o
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam int TMW = $clog2(TIMEOUT + 1);

  logic [0:0]     state;
  logic [2:0]     owner;
  logic           we_q;
  logic [AW-1:0]  addr_q;
  logic [DW-1:0]  wdata_q;
  logic [WCW-1:0] wait_cnt;
  logic [TMW-1:0] tmo_cnt;

  logic [1:0]     win_idx;
  logic [2:0]     win;
  logic           win_we;
  logic [AW-1:0]  win_addr;
  logic [DW-1:0]  win_wdata;
  logic           in_grant;
  logic           ack_hit;
  logic           tmo_hit;
  logic           done;

  // Fixed priority m2 > m0 > m1; once m1 has lost MAX_WAIT arbitrations in a
  // row it is promoted above m0 (m2 always stays on top).
  always_comb begin
    win_idx = 2'd0;
    if (m_req_i[2])
      win_idx = 2'd2;
    else if (wait_cnt == WCW'(MAX_WAIT))
      win_idx = m_req_i[1] ? 2'd1 : 2'd0;
    else
      win_idx = m_req_i[0] ? 2'd0 : 2'd1;
    win = (|m_req_i) ? (3'b001 << win_idx) : 3'b000;
  end

  always_comb begin
    win_we    = m_we_i[0];
    win_addr  = m_addr_i[0 +: AW];
    win_wdata = m_wdata_i[0 +: DW];
    case (win_idx)
      2'd1: begin
        win_we    = m_we_i[1];
        win_addr  = m_addr_i[AW +: AW];
        win_wdata = m_wdata_i[DW +: DW];
      end
      2'd2: begin
        win_we    = m_we_i[2];
        win_addr  = m_addr_i[2*AW +: AW];
        win_wdata = m_wdata_i[2*DW +: DW];
      end
      default: ;
    endcase
  end

  assign in_grant = (state == GRANT);
  // A slave ack on the timeout cycle wins: that is a normal completion.
  assign ack_hit  = in_grant & s_ack_i;
  assign tmo_hit  = in_grant & ~s_ack_i & (tmo_cnt == TMW'(TIMEOUT));
  assign done     = ack_hit | tmo_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 3'b000;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wait_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!m_req_i[1] || win[1])
            wait_cnt <= '0;
          else if (wait_cnt != WCW'(MAX_WAIT))
            wait_cnt <= wait_cnt + 1'b1;
          if (|m_req_i) begin
            state   <= GRANT;
            owner   <= win;
            we_q    <= win_we;
            addr_q  <= win_addr;
            wdata_q <= win_wdata;
            // Counter is restarted so the first GRANT cycle reads as 1.
            tmo_cnt <= TMW'(1);
          end
        end
        GRANT: begin
          if (done) begin
            state   <= IDLE;
            owner   <= 3'b000;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grant_o     = in_grant ? owner : 3'b000;
  assign s_req_o     = in_grant;
  assign s_we_o      = in_grant & we_q;
  assign s_addr_o    = in_grant ? addr_q : '0;
  assign s_wdata_o   = in_grant ? wdata_q : '0;
  assign m_ack_o     = done ? owner : 3'b000;
  assign bus_err_o   = tmo_hit;
  assign m_rdata_o   = (ack_hit && !we_q) ? s_rdata_i : '0;
  assign hold_flag_o = (m_req_i[0] & ~m_ack_o[0]) | (m_req_i[1] & ~m_ack_o[1]);
  assign dbg_state_o = state;

endmodule

// File: tb/tb_rib_arbiter.sv
module tb_rib_arbiter;
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 8;
  localparam int TIMEOUT  = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // driven DUT inputs
  logic          d_rst = 1'b1;
  logic [2:0]    d_req = 3'b000;
  logic [2:0]    d_we = 3'b000;
  logic [31:0]   d_addr [3];
  logic [31:0]   d_wdata [3];
  logic          d_sack = 1'b0;
  logic [31:0]   d_srdata = 32'h0;

  // values for the next cycle, applied just after the rising edge
  logic          n_rst = 1'b1;
  logic [2:0]    n_req = 3'b000;
  logic [2:0]    n_we = 3'b000;
  logic [31:0]   n_addr [3];
  logic [31:0]   n_wdata [3];
  logic          n_sack = 1'b0;
  logic [31:0]   n_srdata = 32'h0;

  logic [3*AW-1:0] m_addr;
  logic [3*DW-1:0] m_wdata;
  assign m_addr  = {d_addr[2], d_addr[1], d_addr[0]};
  assign m_wdata = {d_wdata[2], d_wdata[1], d_wdata[0]};

  logic [DW-1:0] m_rdata;
  logic [2:0]    m_ack;
  logic          bus_err;
  logic [2:0]    grant;
  logic          s_req;
  logic          s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          hold_flag;
  logic          dbg_state;

  rib_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(d_rst),
    .m_req_i(d_req), .m_we_i(d_we), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
    .m_rdata_o(m_rdata), .m_ack_o(m_ack), .bus_err_o(bus_err), .grant_o(grant),
    .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_rdata_i(d_srdata), .s_ack_i(d_sack),
    .hold_flag_o(hold_flag), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Transaction-level reference: who owns the bus, how long it has owned it,
  // and how many arbitrations in a row fetch (m1) has lost.
  int          own = -1;
  int          gcyc = 0;
  int          losses = 0;
  logic        mwe = 1'b0;
  logic [31:0] maddr = 32'h0;
  logic [31:0] mwdata = 32'h0;

  logic [2:0]  e_ack;
  logic [2:0]  exp_q[$];   // completions observed on m_ack_o, in order
  logic [2:0]  o_ack, o_grant;
  logic        o_err, o_sreq;
  logic [31:0] o_rdata;

  function automatic int pick_winner(input logic [2:0] req, input int lost);
    int order [3];
    order[0] = 2;
    if (lost >= MAX_WAIT) begin order[1] = 1; order[2] = 0; end
    else begin order[1] = 0; order[2] = 1; end
    for (int k = 0; k < 3; k++)
      if (req[order[k]]) return order[k];
    return -1;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic step();
    logic [2:0]  e_grant;
    logic        e_sreq, e_swe, e_err, e_hold, fin;
    logic [31:0] e_saddr, e_swdata, e_rdata;
    int          w;
    @(posedge clk);
    #1;
    d_rst = n_rst; d_req = n_req; d_we = n_we; d_sack = n_sack; d_srdata = n_srdata;
    for (int i = 0; i < 3; i++) begin d_addr[i] = n_addr[i]; d_wdata[i] = n_wdata[i]; end
    @(negedge clk);
    e_grant = 3'b000; e_sreq = 1'b0; e_swe = 1'b0; e_err = 1'b0;
    e_saddr = 32'h0; e_swdata = 32'h0; e_rdata = 32'h0; e_ack = 3'b000; fin = 1'b0;
    if (!d_rst && own >= 0) begin
      e_grant  = 3'(1 << own);
      e_sreq   = 1'b1;
      e_swe    = mwe;
      e_saddr  = maddr;
      e_swdata = mwdata;
      fin      = d_sack || (gcyc == TIMEOUT);
      if (fin) e_ack = 3'(1 << own);
      e_err    = !d_sack && (gcyc == TIMEOUT);
      if (d_sack && !mwe) e_rdata = d_srdata;
    end
    e_hold = (d_req[0] && !e_ack[0]) || (d_req[1] && !e_ack[1]);

    o_ack = m_ack; o_grant = grant; o_err = bus_err; o_sreq = s_req; o_rdata = m_rdata;
    check_eq("grant_o", grant, e_grant);
    check_eq("s_req_o", s_req, e_sreq);
    check_eq("s_we_o", s_we, e_swe);
    check_eq("s_addr_o", s_addr, e_saddr);
    check_eq("s_wdata_o", s_wdata, e_swdata);
    check_eq("m_ack_o", m_ack, e_ack);
    check_eq("bus_err_o", bus_err, e_err);
    check_eq("m_rdata_o", m_rdata, e_rdata);
    check_eq("hold_flag_o", hold_flag, e_hold);
    check_eq("dbg_state_o", dbg_state, (!d_rst && own >= 0));
    if (m_ack != 3'b000) exp_q.push_back(m_ack);

    // advance the reference to the state after the coming edge
    if (d_rst) begin
      own = -1; gcyc = 0; losses = 0;
    end else if (own < 0) begin
      w = pick_winner(d_req, losses);
      if (!d_req[1] || w == 1) losses = 0;
      else if (losses < MAX_WAIT) losses++;
      if (w >= 0) begin
        own = w; gcyc = 1; mwe = d_we[w]; maddr = d_addr[w]; mwdata = d_wdata[w];
      end
    end else begin
      if (fin) own = -1;
      else gcyc++;
    end
  endtask

  task automatic set_master(input int i, input logic we);
    n_req[i]   = 1'b1;
    n_we[i]    = we;
    n_addr[i]  = $urandom;
    n_wdata[i] = $urandom;
  endtask

  // Random traffic: masters issue requests and hold them until acked; the
  // slave acks randomly, with stall windows that force timeouts (sometimes
  // acking exactly on the last allowed cycle) and rare resets.
  task automatic random_cycles(input int n);
    logic [2:0] active;
    logic       stall;
    active = 3'b000;
    n_req  = 3'b000;
    for (int c = 0; c < n; c++) begin
      stall = ((c / 400) % 3) == 2;
      for (int i = 0; i < 3; i++) begin
        if (!active[i] && $urandom_range(0, 3) == 0) begin
          active[i] = 1'b1;
          set_master(i, 1'($urandom_range(0, 1)));
        end else if (!active[i]) begin
          n_addr[i] = $urandom; n_wdata[i] = $urandom; n_we[i] = 1'($urandom_range(0, 1));
        end
        n_req[i] = active[i];
      end
      if (stall) n_sack = (own >= 0 && gcyc == TIMEOUT) ? 1'($urandom_range(0, 1)) : 1'b0;
      else       n_sack = ($urandom_range(0, 2) == 0);
      n_srdata = $urandom;
      n_rst    = ($urandom_range(0, 399) == 0);
      step();
      active &= ~e_ack;
    end
    n_rst = 1'b0;
    n_req = 3'b000;
    n_sack = 1'b0;
  endtask

  int cnt, gcnt;

  initial begin
    for (int i = 0; i < 3; i++) begin
      d_addr[i] = 32'h0; d_wdata[i] = 32'h0; n_addr[i] = 32'h0; n_wdata[i] = 32'h0;
    end

    // reset state
    step();
    step();
    check_eq("rst_sreq", o_sreq, 1'b0);
    check_eq("rst_grant", o_grant, 3'b000);
    n_rst = 1'b0;
    step();

    // single m0 read, slave acks one cycle after s_req_o rises
    set_master(0, 1'b0);
    n_sack = 1'b0;
    step();                       // request sampled at the end of this cycle
    step();                       // GRANT cycle 1
    check_eq("t1_grant", o_grant, 3'b001);
    check_eq("t1_noack", o_ack, 3'b000);
    n_sack = 1'b1; n_srdata = 32'hDEADBEEF;
    step();                       // GRANT cycle 2 with ack
    check_eq("t1_ack", o_ack, 3'b001);
    check_eq("t1_rdata", o_rdata, 32'hDEADBEEF);
    n_req = 3'b000; n_sack = 1'b0;
    step();
    check_eq("t1_idle_rdata", o_rdata, 32'h0);

    // all three at once, zero-wait slave: m2, m0, m1
    exp_q.delete();
    for (int i = 0; i < 3; i++) set_master(i, 1'b0);
    n_sack = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() < 3; c++) begin
      step();
      n_req &= ~e_ack;
    end
    check_eq("all3_count", exp_q.size(), 3);
    if (exp_q.size() >= 3) begin
      check_eq("all3_first", exp_q[0], 3'b100);
      check_eq("all3_second", exp_q[1], 3'b001);
      check_eq("all3_third", exp_q[2], 3'b010);
    end
    n_req = 3'b000;
    step();
    step();

    // aging: m0 and m1 request continuously
    exp_q.delete();
    set_master(0, 1'b1);
    set_master(1, 1'b0);
    n_sack = 1'b1;
    for (int c = 0; c < 80 && exp_q.size() < 10; c++) step();
    check_eq("age_count", exp_q.size(), 10);
    if (exp_q.size() >= 10) begin
      for (int k = 0; k < 8; k++) check_eq("age_m0_wins", exp_q[k], 3'b001);
      check_eq("age_m1_9th", exp_q[8], 3'b010);
      check_eq("age_reset_m0", exp_q[9], 3'b001);
    end
    n_req = 3'b000; n_sack = 1'b0;
    step();
    step();

    // slave never acks: m2 write times out at GRANT cycle TIMEOUT
    set_master(2, 1'b1);
    n_sack = 1'b0;
    gcnt = 0;
    cnt = 0;
    o_ack = 3'b000;
    while (o_ack == 3'b000 && cnt < 200) begin
      step();
      n_req &= ~e_ack;
      if (o_grant == 3'b100) gcnt++;
      cnt++;
    end
    check_eq("tmo_cycles", gcnt, TIMEOUT);
    check_eq("tmo_ack", o_ack, 3'b100);
    check_eq("tmo_err", o_err, 1'b1);
    check_eq("tmo_rdata", o_rdata, 32'h0);
    n_req = 3'b000;
    set_master(1, 1'b0);
    n_sack = 1'b1; n_srdata = 32'h1234_5678;
    cnt = 0;
    o_ack = 3'b000;
    while (o_ack == 3'b000 && cnt < 10) begin step(); cnt++; end
    check_eq("after_tmo_ack", o_ack, 3'b010);
    check_eq("after_tmo_err", o_err, 1'b0);
    check_eq("after_tmo_rdata", o_rdata, 32'h1234_5678);
    n_req = 3'b000; n_sack = 1'b0;
    step();

    // slave acks exactly on the last allowed GRANT cycle
    set_master(0, 1'b0);
    gcnt = 0;
    cnt = 0;
    o_ack = 3'b000;
    while (o_ack == 3'b000 && cnt < 200) begin
      n_sack = (own >= 0 && gcyc == TIMEOUT);
      n_srdata = 32'hCAFE_0000 + 32'(cnt);
      step();
      if (o_grant == 3'b001) gcnt++;
      cnt++;
    end
    check_eq("edge_cycles", gcnt, TIMEOUT);
    check_eq("edge_ack", o_ack, 3'b001);
    check_eq("edge_err", o_err, 1'b0);
    n_req = 3'b000; n_sack = 1'b0;
    step();

    // reset in the middle of an m0 transaction
    set_master(0, 1'b0);
    step();
    step();
    step();
    check_eq("mid_pre_grant", o_grant, 3'b001);
    n_rst = 1'b1;
    step();
    check_eq("mid_rst_sreq", o_sreq, 1'b0);
    check_eq("mid_rst_grant", o_grant, 3'b000);
    check_eq("mid_rst_ack", o_ack, 3'b000);
    n_rst = 1'b0;
    step();
    step();
    check_eq("mid_regrant", o_grant, 3'b001);
    n_sack = 1'b1;
    step();
    check_eq("mid_ack", o_ack, 3'b001);
    n_req = 3'b000; n_sack = 1'b0;
    step();

    random_cycles(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
